// File: rtl/mem_port_arbiter_if.sv
// Shared memory port bundle: one request/ack transaction channel between the
// fetch/data arbiter (master) and the memory system (slave).
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  memReq;
    logic                  memWe;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic [DATA_WIDTH-1:0] memWData;
    logic                  memAck;
    logic [DATA_WIDTH-1:0] memRData;

    modport master (
        output memReq, memWe, memAddr, memWData,
        input  memAck, memRData
    );

    modport slave (
        input  memReq, memWe, memAddr, memWData,
        output memAck, memRData
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and M-stage data
// access, keeps a one-entry tagged instruction buffer and raises pipeline stalls.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] i_PCF,
    input  logic                  i_MemReadM,
    input  logic                  i_MemWriteM,
    input  logic [ADDR_WIDTH-1:0] i_ALUOutM,
    input  logic [DATA_WIDTH-1:0] i_WriteDataM,
    output logic [DATA_WIDTH-1:0] o_InstrF,
    output logic                  o_InstrValid,
    output logic [DATA_WIDTH-1:0] o_ReadDataM,
    output logic                  o_StallIF,
    output logic                  o_StallMem,
    mem_port_arbiter_if.master    mem
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        INSTR = 2'd2
    } state_t;

    state_t                state_r;
    state_t                nextState_s;
    logic                  memReq_r;
    logic                  memWe_r;
    logic [ADDR_WIDTH-1:0] memAddr_r;
    logic [DATA_WIDTH-1:0] memWData_r;
    logic                  nextReq_s;
    logic                  nextWe_s;
    logic [ADDR_WIDTH-1:0] nextAddr_s;
    logic [DATA_WIDTH-1:0] nextWData_s;

    logic                  bufValid_r;
    logic [ADDR_WIDTH-1:0] bufTag_r;
    logic [DATA_WIDTH-1:0] bufData_r;

    logic                  dpend_s;
    logic                  hit_s;
    logic                  dataAck_s;
    logic                  fetchAck_s;

    assign dpend_s    = i_MemReadM | i_MemWriteM;
    assign hit_s      = bufValid_r & (bufTag_r == i_PCF);
    assign dataAck_s  = (state_r == DATA) & mem.memAck;
    // Bypass only if the completing fetch is still for the current PC (redirects miss here).
    assign fetchAck_s = (state_r == INSTR) & mem.memAck & (memAddr_r == i_PCF);

    assign o_StallMem   = dpend_s & ~dataAck_s;
    assign o_StallIF    = ~hit_s & ~fetchAck_s;
    assign o_InstrValid = ~o_StallIF;
    assign o_InstrF     = hit_s ? bufData_r : mem.memRData;
    assign o_ReadDataM  = mem.memRData;

    assign mem.memReq   = memReq_r;
    assign mem.memWe    = memWe_r;
    assign mem.memAddr  = memAddr_r;
    assign mem.memWData = memWData_r;

    // Next-state and next request-register decode; data access has priority over fetch.
    always_comb begin
        nextState_s = state_r;
        nextReq_s   = memReq_r;
        nextWe_s    = memWe_r;
        nextAddr_s  = memAddr_r;
        nextWData_s = memWData_r;
        case (state_r)
            IDLE: begin
                if (dpend_s) begin
                    nextState_s = DATA;
                    nextReq_s   = 1'b1;
                    nextWe_s    = i_MemWriteM;
                    nextAddr_s  = i_ALUOutM;
                    nextWData_s = i_WriteDataM;
                end else if (!hit_s) begin
                    nextState_s = INSTR;
                    nextReq_s   = 1'b1;
                    nextWe_s    = 1'b0;
                    nextAddr_s  = i_PCF;
                end else begin
                    nextState_s = IDLE;
                    nextReq_s   = 1'b0;
                end
            end
            DATA, INSTR: begin
                if (mem.memAck) begin
                    nextState_s = IDLE;
                    nextReq_s   = 1'b0;
                end else begin
                    nextState_s = state_r;
                    nextReq_s   = 1'b1;
                end
            end
            default: begin
                nextState_s = IDLE;
                nextReq_s   = 1'b0;
            end
        endcase
    end

    // State and registered memory-port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            memReq_r   <= 1'b0;
            memWe_r    <= 1'b0;
            memAddr_r  <= {ADDR_WIDTH{1'b0}};
            memWData_r <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r    <= nextState_s;
            memReq_r   <= nextReq_s;
            memWe_r    <= nextWe_s;
            memAddr_r  <= nextAddr_s;
            memWData_r <= nextWData_s;
        end
    end

    // Instruction buffer: filled by fetch completion, invalidated by a store to its tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bufValid_r <= 1'b0;
            bufTag_r   <= {ADDR_WIDTH{1'b0}};
            bufData_r  <= {DATA_WIDTH{1'b0}};
        end else if ((state_r == INSTR) && mem.memAck) begin
            bufValid_r <= 1'b1;
            bufTag_r   <= memAddr_r;
            bufData_r  <= mem.memRData;
        end else if (dataAck_s && memWe_r && (memAddr_r == bufTag_r)) begin
            bufValid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level memory/pipeline
// model predicts port activity, stalls and returned instruction/load data.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] pcf, aluOut;
    logic          mRead, mWrite;
    logic [DW-1:0] wdata;
    logic [DW-1:0] instrF, readDataM;
    logic          instrValid, stallIF, stallMem;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) memBus ();

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_PCF       (pcf),
        .i_MemReadM  (mRead),
        .i_MemWriteM (mWrite),
        .i_ALUOutM   (aluOut),
        .i_WriteDataM(wdata),
        .o_InstrF    (instrF),
        .o_InstrValid(instrValid),
        .o_ReadDataM (readDataM),
        .o_StallIF   (stallIF),
        .o_StallMem  (stallMem),
        .mem         (memBus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference memory contents; untouched words hold an address-derived pattern.
    logic [31:0] memArr [logic [31:0]];
    logic [31:0] addrSet [6] = '{32'h0000_0000, 32'h0000_0004, 32'h0000_0008,
                                 32'h0000_0020, 32'h0000_0040, 32'h0000_0100};

    // Model: buffer tag view plus the one transaction expected on the port.
    bit          refValid;
    logic [31:0] refTag;
    bit          expReq, txnData, txnWe;
    logic [31:0] txnAddr, txnWData;
    int          lat, cnt, stallRun, ifRun;
    bit          holdStim, noAckData;
    logic [31:0] nPcf, nAlu, nWd;
    logic        nRead, nWrite;

    task automatic chkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memRd(input logic [31:0] a);
        if (memArr.exists(a)) return memArr[a];
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    function automatic logic [31:0] pickAddr();
        return addrSet[$urandom_range(0, 5)];
    endfunction

    task automatic resetModel();
        refValid = 1'b0; refTag = 32'd0;
        expReq = 1'b0; txnData = 1'b0; txnWe = 1'b0;
        txnAddr = 32'd0; txnWData = 32'd0;
        lat = 0; cnt = 0; stallRun = 0; ifRun = 0;
    endtask

    // One call per cycle: entered just after a rising edge, leaves just after the next.
    task automatic runCycles(input int n);
        for (int c = 0; c < n; c++) begin
            logic ackNow, dpend, hitExp, ackData, ackInstr, expValid, sIF, sMem;
            pcf = nPcf; mRead = nRead; mWrite = nWrite; aluOut = nAlu; wdata = nWd;
            ackNow = expReq && (cnt >= lat) && !(noAckData && txnData);
            if (ackNow) begin
                memBus.memAck   = 1'b1;
                memBus.memRData = txnWe ? $urandom() : memRd(txnAddr);
            end else if (!expReq && !noAckData && $urandom_range(0, 7) == 0) begin
                memBus.memAck   = 1'b1;
                memBus.memRData = $urandom();
            end else begin
                memBus.memAck   = 1'b0;
                memBus.memRData = $urandom();
            end
            #2;
            dpend    = mRead | mWrite;
            hitExp   = refValid && (refTag == pcf);
            ackData  = ackNow && txnData;
            ackInstr = ackNow && !txnData;
            expValid = hitExp || (ackInstr && (txnAddr == pcf));

            chkEq("memReq", 32'(memBus.memReq), 32'(expReq));
            if (expReq) begin
                chkEq("memAddr", memBus.memAddr, txnAddr);
                chkEq("memWe", 32'(memBus.memWe), 32'(txnWe));
                if (txnWe) chkEq("memWData", memBus.memWData, txnWData);
            end
            chkEq("stallMem", 32'(stallMem), 32'(dpend && !ackData));
            chkEq("stallIF", 32'(stallIF), 32'(!expValid));
            chkEq("instrValid", 32'(instrValid), 32'(expValid));
            if (expValid) chkEq("instrF", instrF, memRd(pcf));
            if (ackData && !txnWe) chkEq("readDataM", readDataM, memRd(txnAddr));
            sIF  = stallIF;
            sMem = stallMem;

            // Advance the transaction model to the next cycle.
            if (ackNow) begin
                expReq = 1'b0;
                if (txnData) begin
                    if (txnWe) begin
                        memArr[txnAddr] = txnWData;
                        if (refValid && refTag == txnAddr) refValid = 1'b0;
                    end
                end else begin
                    refValid = 1'b1;
                    refTag   = txnAddr;
                end
            end else if (!expReq) begin
                if (dpend) begin
                    expReq = 1'b1; txnData = 1'b1; txnAddr = aluOut;
                    txnWe = mWrite; txnWData = wdata;
                end else if (!hitExp) begin
                    expReq = 1'b1; txnData = 1'b0; txnAddr = pcf; txnWe = 1'b0;
                end
                if (expReq) begin
                    lat = $urandom_range(0, 3);
                    cnt = 0;
                end
            end else begin
                cnt++;
            end

            // Pipeline-like stimulus: stalled stages hold, fetch bubbles drain M after a few cycles.
            if (!holdStim) begin
                if (!sMem) begin
                    nRead = 1'b0; nWrite = 1'b0;
                    if (ifRun < 3 && $urandom_range(0, 2) != 0) begin
                        nAlu = pickAddr();
                        nWd  = $urandom();
                        if ($urandom_range(0, 1) == 0) nRead = 1'b1; else nWrite = 1'b1;
                    end
                    if (!sIF) begin
                        if ($urandom_range(0, 1) == 0) nPcf = pickAddr();
                    end else if ($urandom_range(0, 7) == 0) begin
                        nPcf = pickAddr();
                    end
                end
            end
            ifRun    = sIF ? ifRun + 1 : 0;
            stallRun = (sIF || sMem) ? stallRun + 1 : 0;
            if (stallRun > 40) begin
                chkEq("watchdog", 32'(stallRun), 32'd40);
                stallRun = 0;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        pcf = 32'd0; aluOut = 32'd0; mRead = 1'b0; mWrite = 1'b0; wdata = 32'd0;
        memBus.memAck = 1'b0; memBus.memRData = 32'd0;
        nPcf = 32'd0; nAlu = 32'd0; nWd = 32'd0; nRead = 1'b0; nWrite = 1'b0;
        holdStim = 1'b0; noAckData = 1'b0;
        resetModel();
        #12;
        chkEq("rstMemReq", 32'(memBus.memReq), 32'd0);
        chkEq("rstMemWe", 32'(memBus.memWe), 32'd0);
        chkEq("rstMemAddr", memBus.memAddr, 32'd0);
        chkEq("rstMemWData", memBus.memWData, 32'd0);
        chkEq("rstStallIF", 32'(stallIF), 32'd1);
        chkEq("rstInstrValid", 32'(instrValid), 32'd0);
        chkEq("rstStallMem", 32'(stallMem), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        runCycles(1500);

        // Force a load to 0x100 that memory never acknowledges, then reset mid-transaction.
        holdStim = 1'b1; noAckData = 1'b1;
        nRead = 1'b1; nWrite = 1'b0; nAlu = 32'h0000_0100;
        for (int k = 0; k < 30 && !(expReq && txnData); k++) runCycles(1);
        chkEq("dataIssued", 32'(expReq && txnData), 32'd1);
        chkEq("dataReqBeforeRst", 32'(memBus.memReq), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chkEq("rstAsyncReq", 32'(memBus.memReq), 32'd0);
        chkEq("rstAsyncAddr", memBus.memAddr, 32'd0);
        mRead = 1'b0; nRead = 1'b0;
        memBus.memAck = 1'b1; memBus.memRData = 32'hDEAD_BEEF;
        #1;
        chkEq("rstStallIFBufInv", 32'(stallIF), 32'd1);
        chkEq("rstStallMemLow", 32'(stallMem), 32'd0);
        @(posedge clk); #1;
        chkEq("lateAckIgnored", 32'(memBus.memReq), 32'd0);
        chkEq("lateAckValid", 32'(instrValid), 32'd0);
        rst_n = 1'b1;
        resetModel();
        holdStim = 1'b0; noAckData = 1'b0;
        runCycles(400);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single shared memory port between instruction fetch (F stage) and data access (M stage) in the pipelined MIPS core. Sequences one memory transaction at a time over a req/ack handshake and keeps a one-entry tagged instruction buffer. Produces the stall requests the hazard logic merges into the pipeline stall/flush network.

## Interface
- ADDR_WIDTH, 32, memory byte-address width
- DATA_WIDTH, 32, memory word width
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_PCF  in  ADDR_WIDTH  fetch address
- i_MemReadM  in  1  load in M stage
- i_MemWriteM  in  1  store in M stage
- i_ALUOutM  in  ADDR_WIDTH  data address
- i_WriteDataM  in  DATA_WIDTH  store data
- o_InstrF  out  DATA_WIDTH  fetched instruction
- o_InstrValid  out  1  o_InstrF valid for i_PCF this cycle
- o_ReadDataM  out  DATA_WIDTH  load data
- o_StallIF  out  1  fetch not ready: freeze PC, insert bubble into D
- o_StallMem  out  1  data access not done: freeze F, D, E, M; bubble into W
- o_MemReq  out  1  transaction request (registered)
- o_MemWe  out  1  write transaction (registered)
- o_MemAddr  out  ADDR_WIDTH  transaction address (registered)
- o_MemWData  out  DATA_WIDTH  write data (registered)
- i_MemAck  in  1  one-cycle completion pulse; read data valid same cycle
- i_MemRData  in  DATA_WIDTH  read data

## Operation
- FSM states IDLE, DATA, INSTR. o_MemReq = (state != IDLE).
- dpend = i_MemReadM | i_MemWriteM. hit = buf_valid & (buf_tag == i_PCF).
- IDLE: dpend -> DATA, latch o_MemAddr=i_ALUOutM, o_MemWe=i_MemWriteM, o_MemWData=i_WriteDataM. Else !hit -> INSTR, latch o_MemAddr=i_PCF, o_MemWe=0. Else stay. Data wins over fetch.
- DATA / INSTR: hold all o_Mem* stable until i_MemAck; on ack -> IDLE. No back-to-back issue; IDLE cycle between transactions.
- INSTR ack: buf_tag<=o_MemAddr, buf_data<=i_MemRData, buf_valid<=1.
- DATA ack with o_MemWe=1 and o_MemAddr==buf_tag: buf_valid<=0 (store invalidates buffer). If same cycle, store invalidate cannot coincide with INSTR fill (one transaction at a time).
- o_StallMem = dpend & !(state==DATA & i_MemAck).
- fetch_ack = (state==INSTR) & i_MemAck & (o_MemAddr==i_PCF).
- o_StallIF = !hit & !fetch_ack; o_InstrValid = !o_StallIF.
- o_InstrF = hit ? buf_data : i_MemRData. o_ReadDataM = i_MemRData (valid only when state==DATA & i_MemAck; else don't-care, drive i_MemRData).
- PC redirect during INSTR: transaction completes, fills buffer with stale tag; no hit; new fetch issued after IDLE.
- Starvation of fetch bounded: o_StallIF bubbles D, so at most 3 data accesses precede next fetch.

## Timing
- Reset (async, immediate): state=IDLE, o_MemReq=0, o_MemWe=0, o_MemAddr=0, o_MemWData=0, buf_valid=0, buf_tag=0, buf_data=0. Combinational outputs after reset with no dpend: o_StallIF=1, o_InstrValid=0, o_StallMem=0.
- Reset mid-transaction: o_MemReq drops asynchronously; transaction abandoned; late ack in IDLE ignored.
- Buffer hit: zero-latency, o_InstrValid same cycle, no request.
- Miss, memory ack latency L (cycles after o_MemReq rises, L>=0): o_MemReq rises edge after miss detected; instruction valid L+1 cycles after miss cycle (bypass on ack cycle).
- Data access: o_StallMem held from first cycle of dpend through cycle before ack; deasserted on ack cycle; pipeline advances on following edge.
- Ack in IDLE: ignored, no state change.
- Fetch pending, data arrives in M during INSTR: fetch completes first; DATA issued from next IDLE.

## Test plan
- Reset, PCF=0x0, ack latency 0: o_MemReq rises cycle 1, addr 0x0; ack cycle 1 -> o_InstrValid=1, o_InstrF=ack data; cycle 2 hit, o_MemReq=0.
- Load at ALUOutM=0x100 with fetch miss at same time: DATA issued first (o_MemWe=0, addr 0x100); o_StallMem=1 until ack with rdata 0xDEADBEEF, o_ReadDataM=0xDEADBEEF; INSTR issued after IDLE.
- Store to 0x40 while buffer holds tag 0x40: o_MemWe=1, o_MemWData=i_WriteDataM; after ack buf_valid=0, next PCF=0x40 refetches.
- Redirect: INSTR to 0x8 in flight (latency 3), PCF changes to 0x20: ack fills tag 0x8, o_StallIF stays 1, next request addr 0x20.
- Assert rst_n low mid-DATA: o_MemReq=0 immediately, state IDLE, buffer invalid; late ack ignored, no outputs change.
